llr_depuncturer: RTL and testbench

Depuncturing stage between the LLR former and the Fano decoder. Takes the punctured soft-bit stream (one LLR per accepted cycle), re-inserts erasures according to a programmable puncture pattern and emits mother-code (rate 1/2) LLR pairs to the decoder. The sync system's depuncturer-advance pulse shifts the pattern alignment by one position, so the sync system can search all puncture phases when decoder sync is lost.

---
 rtl/fano_pkg.sv | 22 ++
 rtl/punct_pos_ctr.sv | 54 +++++
 rtl/llr_depuncturer.sv | 121 ++++++++++++
 tb/tb_llr_depuncturer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fano_pkg.sv
// Shared constants, types and width helpers for the Fano decoder front end.
package fano_pkg;

  localparam int LLR_WIDTH  = 4;
  localparam int MAX_PERIOD = 8;
  localparam int ERASURE    = 0;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic int pat_w(input int max_period);
    return 2 * max_period;
  endfunction

  function automatic int off_w(input int max_period);
    return (max_period < 1) ? 1 : $clog2(2 * max_period);
  endfunction

  function automatic int per_w(input int max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/punct_pos_ctr.sv
// Pattern position and alignment offset counters, both wrapping at 2P-1.
module punct_pos_ctr
  import fano_pkg::*;
#(
  parameter int MAX_PERIOD = fano_pkg::MAX_PERIOD
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [off_w(MAX_PERIOD)-1:0] i_last,
  input  logic                         i_cfg,
  input  logic                         i_next,
  input  logic                         i_step,
  output logic [off_w(MAX_PERIOD)-1:0] o_pos,
  output logic [off_w(MAX_PERIOD)-1:0] o_offset,
  output logic                         o_offset_wrap
);

  localparam int OFF_W = off_w(MAX_PERIOD);

  logic [OFF_W-1:0] r_pos;
  logic [OFF_W-1:0] r_offset;
  logic             r_wrap;
  logic [OFF_W-1:0] w_pos_inc;
  logic [OFF_W-1:0] w_offset_inc;

  assign w_pos_inc    = (r_pos == i_last)    ? '0 : r_pos + OFF_W'(1);
  assign w_offset_inc = (r_offset == i_last) ? '0 : r_offset + OFF_W'(1);

  // A new alignment restarts the pattern walk at the new offset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pos    <= '0;
      r_offset <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_cfg) begin
        r_pos    <= '0;
        r_offset <= '0;
      end else if (i_next) begin
        r_offset <= w_offset_inc;
        r_pos    <= w_offset_inc;
        r_wrap   <= (w_offset_inc == '0);
      end else if (i_step) begin
        r_pos <= w_pos_inc;
      end
    end
  end

  assign o_pos         = r_pos;
  assign o_offset      = r_offset;
  assign o_offset_wrap = r_wrap;

endmodule

// File: rtl/llr_depuncturer.sv
// Re-inserts erasures into a punctured LLR stream and emits rate-1/2 LLR pairs.
module llr_depuncturer
  import fano_pkg::*;
#(
  parameter int LLR_WIDTH  = fano_pkg::LLR_WIDTH,
  parameter int MAX_PERIOD = fano_pkg::MAX_PERIOD
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [pat_w(MAX_PERIOD)-1:0] i_punct_pattern,
  input  logic [per_w(MAX_PERIOD)-1:0] i_punct_period,
  input  logic                         i_cfg_stb,
  input  logic                         i_next_st,
  input  logic [LLR_WIDTH-1:0]         i_llr,
  input  logic                         i_vld,
  output logic                         o_rdy,
  output logic [LLR_WIDTH-1:0]         o_llr0,
  output logic [LLR_WIDTH-1:0]         o_llr1,
  output logic                         o_vld,
  input  logic                         i_rdy,
  output logic [off_w(MAX_PERIOD)-1:0] o_offset,
  output logic                         o_offset_wrap
);

  localparam int PAT_W = pat_w(MAX_PERIOD);
  localparam int OFF_W = off_w(MAX_PERIOD);

  state_t                        r_state;
  logic [PAT_W-1:0]              r_pattern;
  logic [OFF_W-1:0]              r_last;
  logic                          r_slot;
  logic signed [LLR_WIDTH-1:0]   r_buf;
  logic signed [LLR_WIDTH-1:0]   r_llr0;
  logic signed [LLR_WIDTH-1:0]   r_llr1;
  logic                          r_vld;

  logic [PAT_W-1:0]              w_mask;
  logic [PAT_W-1:0]              w_pattern;
  logic [OFF_W-1:0]              w_last;
  logic [OFF_W-1:0]              w_pos;
  logic                          w_run;
  logic                          w_stall;
  logic                          w_bit;
  logic                          w_flush;
  logic                          w_step;
  logic signed [LLR_WIDTH-1:0]   w_val;

  // Clamp P to 1..MAX_PERIOD; an all-erased active pattern means no puncturing.
  always_comb begin : cfg_decode
    int p;
    p = int'(i_punct_period);
    if (p < 1) p = 1;
    else if (p > MAX_PERIOD) p = MAX_PERIOD;
    w_mask = '0;
    for (int k = 0; k < PAT_W; k++) w_mask[k] = (k < 2 * p);
    w_pattern = i_punct_pattern & w_mask;
    if (w_pattern == '0) w_pattern = w_mask;
    w_last = OFF_W'(2 * p - 1);
  end

  assign w_run   = (r_state == RUN);
  assign w_stall = r_vld & ~i_rdy;
  assign w_bit   = r_pattern[w_pos];
  assign w_flush = i_cfg_stb | i_next_st;
  assign w_step  = w_run & ~w_stall & ~w_flush & (~w_bit | i_vld);
  assign o_rdy   = w_run & ~w_stall & ~w_flush & w_bit;
  assign w_val   = w_bit ? i_llr : LLR_WIDTH'(ERASURE);

  punct_pos_ctr #(
    .MAX_PERIOD (MAX_PERIOD)
  ) u_pos_ctr (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_last        (r_last),
    .i_cfg         (i_cfg_stb),
    .i_next        (i_next_st & ~i_cfg_stb),
    .i_step        (w_step),
    .o_pos         (w_pos),
    .o_offset      (o_offset),
    .o_offset_wrap (o_offset_wrap)
  );

  // Pair assembly: slot 0 parks the first LLR, slot 1 completes the output pair.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_last    <= '0;
      r_slot    <= 1'b0;
      r_buf     <= '0;
      r_llr0    <= '0;
      r_llr1    <= '0;
      r_vld     <= 1'b0;
    end else begin
      if (i_cfg_stb) begin
        r_state   <= RUN;
        r_pattern <= w_pattern;
        r_last    <= w_last;
      end
      if (r_vld && i_rdy) r_vld <= 1'b0;
      if (w_flush) begin
        r_slot <= 1'b0;
      end else if (w_step) begin
        if (!r_slot) begin
          r_buf  <= w_val;
          r_slot <= 1'b1;
        end else begin
          r_llr0 <= r_buf;
          r_llr1 <= w_val;
          r_vld  <= 1'b1;
          r_slot <= 1'b0;
        end
      end
    end
  end

  assign o_llr0 = r_llr0;
  assign o_llr1 = r_llr1;
  assign o_vld  = r_vld;

endmodule

// File: tb/tb_llr_depuncturer.sv
// Scoreboard bench for llr_depuncturer: a mother-code stream model feeds an expected-pair queue.
module tb_llr_depuncturer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] i_punct_pattern;
  logic [3:0]  i_punct_period;
  logic        i_cfg_stb, i_next_st;
  logic [3:0]  i_llr;
  logic        i_vld, o_rdy;
  logic [3:0]  o_llr0, o_llr1;
  logic        o_vld, i_rdy;
  logic [3:0]  o_offset;
  logic        o_offset_wrap;

  llr_depuncturer #(.LLR_WIDTH(4), .MAX_PERIOD(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_punct_pattern (i_punct_pattern),
    .i_punct_period  (i_punct_period),
    .i_cfg_stb       (i_cfg_stb),
    .i_next_st       (i_next_st),
    .i_llr           (i_llr),
    .i_vld           (i_vld),
    .o_rdy           (o_rdy),
    .o_llr0          (o_llr0),
    .o_llr1          (o_llr1),
    .o_vld           (o_vld),
    .i_rdy           (i_rdy),
    .o_offset        (o_offset),
    .o_offset_wrap   (o_offset_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int b;} pair_t;
  pair_t exp_q[$];

  int n_checks = 0;
  int n_errs   = 0;
  bit rand_rdy = 1'b0;

  // Reference model: the mother-code position sequence starting at the alignment offset.
  int mpat[16];
  int mP = 1, mpos = 0, moff = 0, mbuf = 0;
  bit mhave = 1'b0;

  function automatic void chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic void push_val(int v);
    pair_t pr;
    if (!mhave) begin
      mbuf  = v;
      mhave = 1'b1;
    end else begin
      pr.a = mbuf;
      pr.b = v;
      exp_q.push_back(pr);
      mhave = 1'b0;
    end
    mpos = (mpos + 1) % (2 * mP);
  endfunction

  function automatic void fill_erasures();
    while (mpat[mpos] == 0) push_val(0);
  endfunction

  function automatic void model_flush(int start);
    mpos  = start;
    mhave = 1'b0;
    fill_erasures();
  endfunction

  function automatic void model_accept(int v);
    fill_erasures();
    push_val(v & 15);
    fill_erasures();
  endfunction

  function automatic void model_cfg(logic [15:0] pat, int per);
    int p;
    int any;
    p = (per < 1) ? 1 : ((per > 8) ? 8 : per);
    any = 0;
    for (int k = 0; k < 16; k++) begin
      mpat[k] = (k < 2 * p) ? int'(pat[k]) : 0;
      any = any | mpat[k];
    end
    if (any == 0) for (int k = 0; k < 2 * p; k++) mpat[k] = 1;
    mP   = p;
    moff = 0;
    model_flush(0);
  endfunction

  // Monitor: every completed output handshake must match the head of the queue.
  initial begin
    pair_t pr;
    forever begin
      @(negedge clk);
      if (reset_n && o_vld && i_rdy) begin
        if (exp_q.size() == 0) begin
          chk("pair_unexpected", 1, 0);
        end else begin
          pr = exp_q.pop_front();
          chk("pair_llr0", int'(o_llr0), pr.a);
          chk("pair_llr1", int'(o_llr1), pr.b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) i_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int v);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    i_vld = 1'b1;
    i_llr = 4'(v);
    while (!done) begin
      @(negedge clk);
      if (o_rdy) begin
        model_accept(v);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 300) begin
        chk("send_timeout", 1, 0);
        done = 1'b1;
      end
    end
    i_vld = 1'b0;
  endtask

  task automatic pulse_next();
    i_next_st = 1'b1;
    @(posedge clk);
    #1;
    i_next_st = 1'b0;
    moff = (moff + 1) % (2 * mP);
    model_flush(moff);
    chk("offset_after_next", int'(o_offset), moff);
    chk("wrap_after_next", int'(o_offset_wrap), (moff == 0) ? 1 : 0);
  endtask

  task automatic do_cfg(input logic [15:0] pat, input int per, input bit with_next);
    i_punct_pattern = pat;
    i_punct_period  = 4'(per);
    i_cfg_stb = 1'b1;
    i_next_st = with_next;
    @(posedge clk);
    #1;
    i_cfg_stb = 1'b0;
    i_next_st = 1'b0;
    model_cfg(pat, per);
    chk("offset_after_cfg", int'(o_offset), 0);
    chk("wrap_after_cfg", int'(o_offset_wrap), 0);
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    i_rdy = 1'b1;
    i_vld = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_punct_pattern = '0;
    i_punct_period = '0;
    i_cfg_stb = 1'b0;
    i_next_st = 1'b0;
    i_llr = '0;
    i_vld = 1'b0;
    i_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", int'(o_rdy), 0);
    chk("rst_vld", int'(o_vld), 0);
    chk("rst_llr0", int'(o_llr0), 0);
    chk("rst_llr1", int'(o_llr1), 0);
    chk("rst_offset", int'(o_offset), 0);
    chk("rst_wrap", int'(o_offset_wrap), 0);
    reset_n = 1'b1;
    i_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rdy", int'(o_rdy), 0);
    end
    @(posedge clk);
    #1;
    i_vld = 1'b0;

    // P=1, no puncturing
    do_cfg(16'h0003, 1, 1'b0);
    @(negedge clk);
    chk("p1_rdy", int'(o_rdy), 1);
    @(posedge clk);
    #1;
    for (int v = 1; v <= 4; v++) send(v);
    drain();

    // P=3, pattern 1,1,0,1,1,0
    do_cfg(16'h001B, 3, 1'b0);
    send(5);
    send(6);
    @(negedge clk);
    chk("erased_pos_rdy", int'(o_rdy), 0);
    @(posedge clk);
    #1;
    send(7);
    send(8);
    drain();

    repeat (6) pulse_next();
    pulse_next();
    pulse_next();
    drain();
    send(5);
    send(6);
    drain();

    // Output stall: held pair must stay put and no input may slip in
    do_cfg(16'h0003, 1, 1'b0);
    i_rdy = 1'b0;
    send(3);
    send(4);
    i_vld = 1'b1;
    i_llr = 4'd5;
    repeat (10) begin
      @(negedge clk);
      chk("hold_vld", int'(o_vld), 1);
      chk("hold_llr0", int'(o_llr0), 3);
      chk("hold_llr1", int'(o_llr1), 4);
      chk("hold_rdy", int'(o_rdy), 0);
    end
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    i_rdy = 1'b1;
    send(5);
    send(6);
    drain();

    // Alignment advance with a partial slot-0 value, then with a held pair
    send(1);
    send(2);
    send(3);
    pulse_next();
    send(4);
    send(5);
    drain();
    i_rdy = 1'b0;
    send(6);
    send(7);
    pulse_next();
    @(negedge clk);
    chk("next_keep_vld", int'(o_vld), 1);
    chk("next_keep_llr0", int'(o_llr0), 6);
    chk("next_keep_llr1", int'(o_llr1), 7);
    @(posedge clk);
    #1;
    drain();

    pulse_next();
    do_cfg(16'h0003, 1, 1'b1);
    drain();

    // Reset in the middle of operation
    pulse_next();
    i_rdy = 1'b0;
    send(2);
    send(3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("midrst_vld", int'(o_vld), 0);
    chk("midrst_llr0", int'(o_llr0), 0);
    chk("midrst_llr1", int'(o_llr1), 0);
    chk("midrst_rdy", int'(o_rdy), 0);
    chk("midrst_offset", int'(o_offset), 0);
    reset_n = 1'b1;
    i_rdy = 1'b1;
    i_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_idle_rdy", int'(o_rdy), 0);
      chk("midrst_idle_vld", int'(o_vld), 0);
    end
    @(posedge clk);
    #1;
    i_vld = 1'b0;

    // All-zero active pattern (upper bits set but ignored)
    do_cfg(16'hFFF0, 2, 1'b0);
    for (int v = 1; v <= 4; v++) send(v);
    drain();

    // Randomized configurations, data, backpressure and alignment advances
    for (int r = 0; r < 30; r++) begin
      logic [15:0] pat;
      int per;
      int n;
      per = $urandom_range(0, 15);
      pat = 16'($urandom);
      if ($urandom_range(0, 5) == 0) pat = '0;
      do_cfg(pat, per, 1'b0);
      for (int s = 0; s < 3; s++) begin
        rand_rdy = 1'b1;
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send($urandom_range(0, 15));
        end
        drain();
        if ($urandom_range(0, 1) == 1) begin
          pulse_next();
          drain();
        end
      end
    end

    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
